// File: rtl/sccb_init_sequencer.sv
// Camera power-up sequencer: times pwdn/cam_rstn release, then walks a ROM
// register table and issues one SCCB write per entry via a req/ack handshake.
module sccb_init_sequencer #(
  parameter int PWDN_CYCLES = 10000,
  parameter int RST_CYCLES  = 10000,
  parameter int BOOT_CYCLES = 100000,
  parameter int GAP_CYCLES  = 256,
  parameter int ROM_AW      = 8,
  parameter int MAX_RETRY   = 3
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              wr_req,
  output logic [7:0]        wr_reg,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  input  logic              wr_nack,
  output logic              pwdn,
  output logic              cam_rstn,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  typedef enum logic [3:0] {
    S_PWDN_WAIT, S_RST_WAIT, S_BOOT_WAIT, S_FETCH, S_LATCH, S_ISSUE,
    S_WAIT_ACK, S_GAP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  localparam logic [19:0] PWDN_LAST = 20'(PWDN_CYCLES - 1);
  localparam logic [19:0] RST_LAST  = 20'(RST_CYCLES - 1);
  localparam logic [19:0] BOOT_LAST = 20'(BOOT_CYCLES - 1);
  localparam logic [19:0] GAP_LAST  = 20'(GAP_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
  localparam logic [ROM_AW-1:0] ADDR_LAST = {ROM_AW{1'b1}};

  state_t            state_r, state_s;
  logic [19:0]       cnt_r, cnt_s;
  logic [19:0]       dly_last_r, dly_last_s;
  logic [7:0]        retry_r, retry_s;
  logic [ROM_AW-1:0] rom_addr_r, rom_addr_s;
  logic              wr_req_r, wr_req_s;
  logic [7:0]        wr_reg_r, wr_reg_s;
  logic [7:0]        wr_data_r, wr_data_s;
  logic              pwdn_r, pwdn_s;
  logic              cam_rstn_r, cam_rstn_s;
  logic              busy_r, busy_s;
  logic              cfg_done_r, cfg_done_s;
  logic              cfg_err_r, cfg_err_s;

  // State and output registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_r    <= S_PWDN_WAIT;
      cnt_r      <= 20'd0;
      dly_last_r <= 20'd0;
      retry_r    <= 8'd0;
      rom_addr_r <= {ROM_AW{1'b0}};
      wr_req_r   <= 1'b0;
      wr_reg_r   <= 8'd0;
      wr_data_r  <= 8'd0;
      pwdn_r     <= 1'b1;
      cam_rstn_r <= 1'b0;
      busy_r     <= 1'b1;
      cfg_done_r <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      dly_last_r <= dly_last_s;
      retry_r    <= retry_s;
      rom_addr_r <= rom_addr_s;
      wr_req_r   <= wr_req_s;
      wr_reg_r   <= wr_reg_s;
      wr_data_r  <= wr_data_s;
      pwdn_r     <= pwdn_s;
      cam_rstn_r <= cam_rstn_s;
      busy_r     <= busy_s;
      cfg_done_r <= cfg_done_s;
      cfg_err_r  <= cfg_err_s;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    dly_last_s = dly_last_r;
    retry_s    = retry_r;
    rom_addr_s = rom_addr_r;
    wr_req_s   = wr_req_r;
    wr_reg_s   = wr_reg_r;
    wr_data_s  = wr_data_r;
    pwdn_s     = pwdn_r;
    cam_rstn_s = cam_rstn_r;
    case (state_r)
      S_PWDN_WAIT: begin
        if (cnt_r == PWDN_LAST) begin
          pwdn_s  = 1'b0;
          state_s = S_RST_WAIT;
        end else begin
          state_s = S_PWDN_WAIT;
        end
      end
      S_RST_WAIT: begin
        if (cnt_r == RST_LAST) begin
          cam_rstn_s = 1'b1;
          state_s    = S_BOOT_WAIT;
        end else begin
          state_s = S_RST_WAIT;
        end
      end
      S_BOOT_WAIT: begin
        if (cnt_r == BOOT_LAST) state_s = S_FETCH;
        else                    state_s = S_BOOT_WAIT;
      end
      S_FETCH: state_s = S_LATCH;
      S_LATCH: begin
        if (rom_data[15:8] == 8'hFF) begin
          state_s = S_DONE;
        end else if (rom_data[15:8] == 8'hFE) begin
          dly_last_s = {2'b00, rom_data[7:0], 10'd0} - 20'd1;
          if (rom_data[7:0] != 8'd0) begin
            state_s = S_DELAY;
          end else if (rom_addr_r == ADDR_LAST) begin
            state_s = S_DONE;
          end else begin
            rom_addr_s = rom_addr_r + ROM_AW'(1'b1);
            state_s    = S_FETCH;
          end
        end else begin
          wr_reg_s  = rom_data[15:8];
          wr_data_s = rom_data[7:0];
          state_s   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wr_req_s = 1'b1;
        state_s  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // start is deliberately not looked at here, so an ack always wins
        if (wr_ack) begin
          wr_req_s = 1'b0;
          if (!wr_nack) begin
            retry_s = 8'd0;
            if (rom_addr_r == ADDR_LAST) begin
              state_s = S_DONE;
            end else begin
              rom_addr_s = rom_addr_r + ROM_AW'(1'b1);
              state_s    = S_GAP;
            end
          end else if (retry_r < RETRY_MAX) begin
            retry_s = retry_r + 8'd1;
            state_s = S_GAP;
          end else begin
            state_s = S_ERROR;
          end
        end else begin
          state_s = S_WAIT_ACK;
        end
      end
      S_GAP: begin
        if (cnt_r == GAP_LAST) state_s = S_FETCH;
        else                   state_s = S_GAP;
      end
      S_DELAY: begin
        if (cnt_r != dly_last_r) begin
          state_s = S_DELAY;
        end else if (rom_addr_r == ADDR_LAST) begin
          state_s = S_DONE;
        end else begin
          rom_addr_s = rom_addr_r + ROM_AW'(1'b1);
          state_s    = S_FETCH;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          rom_addr_s = {ROM_AW{1'b0}};
          retry_s    = 8'd0;
          pwdn_s     = 1'b1;
          cam_rstn_s = 1'b0;
          state_s    = S_PWDN_WAIT;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = S_PWDN_WAIT;
    endcase

    // Every timed state counts from zero on entry
    if (state_s != state_r) cnt_s = 20'd0;
    else                    cnt_s = cnt_r + 20'd1;

    cfg_done_s = (state_s == S_DONE);
    cfg_err_s  = (state_s == S_ERROR);
    busy_s     = !(cfg_done_s || cfg_err_s);
  end

  assign rom_addr = rom_addr_r;
  assign wr_req   = wr_req_r;
  assign wr_reg   = wr_reg_r;
  assign wr_data  = wr_data_r;
  assign pwdn     = pwdn_r;
  assign cam_rstn = cam_rstn_r;
  assign busy     = busy_r;
  assign cfg_done = cfg_done_r;
  assign cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer: short timing parameters, a
// behavioural synchronous ROM and a hand-driven SCCB ack/nack responder.
module tb_sccb_init_sequencer;

  localparam int GAP = 8;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        wr_req;
  logic [7:0]  wr_reg, wr_data;
  logic        wr_ack = 1'b0, wr_nack = 1'b0;
  logic        pwdn, cam_rstn, busy, cfg_done, cfg_err;

  logic [15:0] rom_mem [0:7];
  int          cyc;
  int          n_vec = 0, n_err = 0;
  logic [7:0]  got_reg, got_data;
  int          got_rise, prev_rise;

  sccb_init_sequencer #(
    .PWDN_CYCLES(10), .RST_CYCLES(20), .BOOT_CYCLES(30),
    .GAP_CYCLES(GAP), .ROM_AW(3), .MAX_RETRY(3)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_req(wr_req), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_nack(wr_nack),
    .pwdn(pwdn), .cam_rstn(cam_rstn), .busy(busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) rom_data <= rom_mem[rom_addr];

  // cyc = number of rising edges seen since PRESETN released
  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic load_table(input logic [15:0] t0, t1, t2, t3);
    rom_mem[0] = t0; rom_mem[1] = t1; rom_mem[2] = t2; rom_mem[3] = t3;
    for (int i = 4; i < 8; i++) rom_mem[i] = 16'hFF00;
  endtask

  // Waits for a request, checks it stays stable, then acks it (optionally with nack/start)
  task automatic serve(input logic nack, input logic with_start);
    int t = 0;
    while (wr_req !== 1'b1 && t < 20000) begin @(negedge PCLK); t++; end
    n_vec++;
    if (wr_req !== 1'b1) begin n_err++; $display("FAIL req_timeout: wr_req=%b required 1", wr_req); end
    prev_rise = got_rise;
    got_rise = cyc; got_reg = wr_reg; got_data = wr_data;
    for (int k = 0; k < 2; k++) begin
      @(negedge PCLK);
      n_vec++;
      if ({wr_req, wr_reg, wr_data} !== {1'b1, got_reg, got_data}) begin
        n_err++;
        $display("FAIL req_stable: req/reg/data=%b/%h/%h required 1/%h/%h", wr_req, wr_reg, wr_data, got_reg, got_data);
      end
    end
    wr_ack = 1'b1; wr_nack = nack; start = with_start;
    @(negedge PCLK);
    wr_ack = 1'b0; wr_nack = 1'b0; start = 1'b0;
    n_vec++;
    if (wr_req !== 1'b0) begin n_err++; $display("FAIL req_drop: wr_req=%b required 0", wr_req); end
  endtask

  task automatic wait_end();
    int t = 0;
    while (cfg_done !== 1'b1 && cfg_err !== 1'b1 && t < 20000) begin @(negedge PCLK); t++; end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge PCLK); start = 1'b0;
  endtask

  task automatic test_reset();
    load_table(16'h1280, 16'h1101, 16'hFF00, 16'hFF00);
    PRESETN = 1'b0;
    repeat (3) @(negedge PCLK);
    n_vec++;
    if ({pwdn, cam_rstn, wr_req, busy, cfg_done, cfg_err} !== 6'b100100) begin
      n_err++; $display("FAIL reset_ctrl: pwdn/rstn/req/busy/done/err=%b required 100100", {pwdn, cam_rstn, wr_req, busy, cfg_done, cfg_err});
    end
    n_vec++;
    if ({wr_reg, wr_data, rom_addr} !== 19'd0) begin
      n_err++; $display("FAIL reset_data: reg/data/addr=%h/%h/%0d required 0/0/0", wr_reg, wr_data, rom_addr);
    end
  endtask

  task automatic test_powerup();
    PRESETN = 1'b1;
    while (cyc < 9) @(negedge PCLK);
    n_vec++; if (pwdn !== 1'b1) begin n_err++; $display("FAIL pwdn_early: pwdn=%b at cyc 9 required 1", pwdn); end
    @(negedge PCLK);
    n_vec++; if (pwdn !== 1'b0) begin n_err++; $display("FAIL pwdn_fall: pwdn=%b at cyc 10 required 0", pwdn); end
    while (cyc < 29) @(negedge PCLK);
    n_vec++; if (cam_rstn !== 1'b0) begin n_err++; $display("FAIL rstn_early: cam_rstn=%b at cyc 29 required 0", cam_rstn); end
    @(negedge PCLK);
    n_vec++; if (cam_rstn !== 1'b1) begin n_err++; $display("FAIL rstn_rise: cam_rstn=%b at cyc 30 required 1", cam_rstn); end
    while (cyc < 40) @(negedge PCLK);
    pulse_start();
    while (cyc < 62) @(negedge PCLK);
    n_vec++; if (wr_req !== 1'b0) begin n_err++; $display("FAIL req_early: wr_req=%b at cyc 62 required 0", wr_req); end
    @(negedge PCLK);
    n_vec++; if (wr_req !== 1'b1) begin n_err++; $display("FAIL req_first: wr_req=%b at cyc 63 required 1", wr_req); end
  endtask

  task automatic test_basic_table();
    serve(1'b0, 1'b1);
    n_vec++; if ({got_reg, got_data} !== 16'h1280) begin n_err++; $display("FAIL write0: %h required 1280", {got_reg, got_data}); end
    n_vec++; if ({pwdn, busy} !== 2'b01) begin n_err++; $display("FAIL start_with_ack: pwdn/busy=%b required 01", {pwdn, busy}); end
    serve(1'b0, 1'b0);
    n_vec++; if ({got_reg, got_data} !== 16'h1101) begin n_err++; $display("FAIL write1: %h required 1101", {got_reg, got_data}); end
    n_vec++; if (got_rise - prev_rise !== GAP + 6) begin n_err++; $display("FAIL write_spacing: %0d required %0d", got_rise - prev_rise, GAP + 6); end
    wait_end();
    n_vec++;
    if ({cfg_done, cfg_err, busy, wr_req, rom_addr} !== {4'b1000, 3'd2}) begin
      n_err++; $display("FAIL basic_done: done/err/busy/req=%b addr=%0d required 1000 addr 2", {cfg_done, cfg_err, busy, wr_req}, rom_addr);
    end
  endtask

  task automatic test_retry_recover();
    pulse_start();
    n_vec++;
    if ({pwdn, cam_rstn, busy, cfg_done, rom_addr} !== {4'b1010, 3'd0}) begin
      n_err++; $display("FAIL restart: pwdn/rstn/busy/done=%b addr=%0d required 1010 addr 0", {pwdn, cam_rstn, busy, cfg_done}, rom_addr);
    end
    for (int i = 0; i < 4; i++) begin
      serve(i < 3, 1'b0);
      n_vec++; if (got_reg !== 8'h12) begin n_err++; $display("FAIL retry_reg%0d: %h required 12", i, got_reg); end
    end
    serve(1'b0, 1'b0);
    n_vec++; if (got_reg !== 8'h11) begin n_err++; $display("FAIL retry_next: %h required 11", got_reg); end
    wait_end();
    n_vec++; if ({cfg_done, cfg_err} !== 2'b10) begin n_err++; $display("FAIL retry_done: done/err=%b required 10", {cfg_done, cfg_err}); end
  endtask

  task automatic test_retry_exhaust();
    pulse_start();
    for (int i = 0; i < 4; i++) serve(1'b1, 1'b0);
    n_vec++;
    if ({cfg_err, cfg_done, wr_req, busy, rom_addr} !== {4'b1000, 3'd0}) begin
      n_err++; $display("FAIL exhaust: err/done/req/busy=%b addr=%0d required 1000 addr 0", {cfg_err, cfg_done, wr_req, busy}, rom_addr);
    end
    repeat (30) @(negedge PCLK);
    n_vec++; if ({wr_req, cfg_err} !== 2'b01) begin n_err++; $display("FAIL exhaust_idle: req/err=%b required 01", {wr_req, cfg_err}); end
    load_table(16'h1280, 16'hFE02, 16'h1101, 16'hFF00);
    pulse_start();
    n_vec++;
    if ({pwdn, cam_rstn, cfg_err, busy} !== 4'b1001) begin
      n_err++; $display("FAIL err_restart: pwdn/rstn/err/busy=%b required 1001", {pwdn, cam_rstn, cfg_err, busy});
    end
  endtask

  task automatic test_delay_entry();
    serve(1'b0, 1'b0);
    n_vec++; if ({got_reg, got_data} !== 16'h1280) begin n_err++; $display("FAIL delay_w0: %h required 1280", {got_reg, got_data}); end
    repeat (40) @(negedge PCLK);
    wr_ack = 1'b1; wr_nack = 1'b1; @(negedge PCLK); wr_ack = 1'b0; wr_nack = 1'b0;
    serve(1'b0, 1'b0);
    n_vec++; if ({got_reg, got_data} !== 16'h1101) begin n_err++; $display("FAIL delay_w1: %h required 1101", {got_reg, got_data}); end
    n_vec++; if (got_rise - prev_rise !== 2048 + GAP + 8) begin n_err++; $display("FAIL delay_spacing: %0d required %0d", got_rise - prev_rise, 2048 + GAP + 8); end
    wait_end();
    n_vec++; if ({cfg_done, rom_addr} !== {1'b1, 3'd3}) begin n_err++; $display("FAIL delay_done: done=%b addr=%0d required 1 addr 3", cfg_done, rom_addr); end
  endtask

  task automatic test_table_wrap();
    for (int i = 0; i < 8; i++) rom_mem[i] = {8'h20 + 8'(i), 8'(i)};
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      serve(1'b0, 1'b0);
      n_vec++;
      if ({got_reg, got_data} !== {8'h20 + 8'(i), 8'(i)}) begin
        n_err++; $display("FAIL wrap_w%0d: %h required %h", i, {got_reg, got_data}, {8'h20 + 8'(i), 8'(i)});
      end
    end
    wait_end();
    repeat (20) @(negedge PCLK);
    n_vec++;
    if ({cfg_done, wr_req, rom_addr} !== {2'b10, 3'd7}) begin
      n_err++; $display("FAIL wrap_end: done/req=%b addr=%0d required 10 addr 7", {cfg_done, wr_req}, rom_addr);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    load_table(16'h1280, 16'h1101, 16'hFF00, 16'hFF00);
    pulse_start();
    while (wr_req !== 1'b1 && t < 20000) begin @(negedge PCLK); t++; end
    PRESETN = 1'b0;
    #1;
    n_vec++;
    if ({wr_req, pwdn, cam_rstn, busy, rom_addr} !== {4'b0101, 3'd0}) begin
      n_err++; $display("FAIL async_reset: req/pwdn/rstn/busy=%b addr=%0d required 0101 addr 0", {wr_req, pwdn, cam_rstn, busy}, rom_addr);
    end
    @(negedge PCLK);
    PRESETN = 1'b1;
    while (cyc < 10) @(negedge PCLK);
    n_vec++; if (pwdn !== 1'b0) begin n_err++; $display("FAIL rerun_pwdn: pwdn=%b at cyc 10 required 0", pwdn); end
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    wait_end();
    n_vec++;
    if ({cfg_done, busy, rom_addr} !== {2'b10, 3'd2}) begin
      n_err++; $display("FAIL rerun_done: done/busy=%b addr=%0d required 10 addr 2", {cfg_done, busy}, rom_addr);
    end
  endtask

  initial begin
    got_rise = 0; prev_rise = 0;
    test_reset();
    test_powerup();
    test_basic_table();
    test_retry_recover();
    test_retry_exhaust();
    test_delay_entry();
    test_table_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_init_sequencer.md
# sccb_init_sequencer

Power-up and register-load sequencer for the OV-series camera. Drives camera `pwdn` and `cam_rstn` through the required power-on timing, then walks a register table in an external synchronous ROM and issues one SCCB write per entry to the SCCB master through a req/ack handshake. It replaces the hard-coded sequencing inside the SCCB configuration path: it sits between the reset/clock logic (`PCLK` = camera `xclk` domain, `PRESETN` = CCC lock AND power-on reset) and the SCCB bit-level master.

## Interface
- `PWDN_CYCLES`, 10000: cycles `pwdn` is held high after reset release.
- `RST_CYCLES`, 10000: cycles `cam_rstn` is held low after `pwdn` falls.
- `BOOT_CYCLES`, 100000: settle cycles after `cam_rstn` rises, before the first write.
- `GAP_CYCLES`, 256: idle cycles between consecutive writes and before each retry.
- `ROM_AW`, 8: ROM address width.
- `MAX_RETRY`, 3: retries per entry after a NACK.
- All cycle parameters are 1..2^20-1. The delay counter is 20 bits.

Ports:
- `PCLK`  in  1  clock.
- `PRESETN`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse. Re-runs the full sequence from DONE or ERROR.
- `rom_addr`  out  ROM_AW  table address.
- `rom_data`  in  16  {reg[15:8], val[7:0]}. Valid the cycle after `rom_addr` changes.
- `wr_req`  out  1  write request to the SCCB master.
- `wr_reg`  out  8  register address. Stable while `wr_req`=1.
- `wr_data`  out  8  register value. Stable while `wr_req`=1.
- `wr_ack`  in  1  one-cycle pulse: the SCCB transaction has finished.
- `wr_nack`  in  1  sampled with `wr_ack`. 1 means the slave did not acknowledge.
- `pwdn`  out  1  camera power-down, active high.
- `cam_rstn`  out  1  camera reset, active low.
- `busy`  out  1  high in every state except DONE and ERROR.
- `cfg_done`  out  1  level. Table completed successfully.
- `cfg_err`  out  1  level. Retries exhausted on some entry.

## Operation
- States:
  - PWDN_WAIT → RST_WAIT → BOOT_WAIT → FETCH → LATCH → {ISSUE | DELAY | DONE}.
  - ISSUE → WAIT_ACK → GAP → FETCH.
  - Additional terminal state: ERROR.
- Reset values:
  - State PWDN_WAIT.
  - `pwdn`=1, `cam_rstn`=0, `wr_req`=0.
  - `wr_reg`=0, `wr_data`=0, `rom_addr`=0.
  - `busy`=1, `cfg_done`=0, `cfg_err`=0.
  - Retry count 0.
- Reset release: the sequencer starts automatically. No `start` pulse is needed.
- PWDN_WAIT: after PWDN_CYCLES, `pwdn`←0 and go to RST_WAIT.
- RST_WAIT: after RST_CYCLES, `cam_rstn`←1 and go to BOOT_WAIT.
- BOOT_WAIT: after BOOT_CYCLES, go to FETCH.
- FETCH: `rom_addr` is presented. The next state is LATCH.
- LATCH: capture `rom_data` and decode it:
  - reg=0xFF: end marker. Go to DONE.
  - reg=0xFE: delay entry. Go to DELAY for val×1024 cycles (val=0 means 0 cycles), then advance.
  - Otherwise: load `wr_reg`/`wr_data` and go to ISSUE.
- ISSUE: `wr_req`←1, then go to WAIT_ACK.
- WAIT_ACK: hold `wr_req`, `wr_reg` and `wr_data` until `wr_ack`. `wr_req` drops the cycle after `wr_ack`.
  - `wr_nack`=0: reset the retry count, advance `rom_addr`, go to GAP.
  - `wr_nack`=1 and count<MAX_RETRY: count+1, same address, go to GAP, then re-fetch.
  - `wr_nack`=1 and count=MAX_RETRY: go to ERROR.
- Advancing the address: `rom_addr`+1. If `rom_addr` was 2^ROM_AW-1, the table is treated as ended: go to DONE with no wrap.
- DONE: `cfg_done`=1. ERROR: `cfg_err`=1.
- In DONE and ERROR, `pwdn` and `cam_rstn` keep their values.
- `start` in DONE or ERROR:
  - Clears `cfg_done`, `cfg_err`, `rom_addr` and the retry count.
  - Sets `pwdn`=1 and `cam_rstn`=0.
  - Enters PWDN_WAIT.
- `start` while `busy`=1 is ignored.
- `wr_ack` outside WAIT_ACK is ignored.

## Timing
- Each wait of N cycles lasts exactly N `PCLK` cycles, measured from the cycle the state is entered.
- `pwdn` falls exactly PWDN_CYCLES cycles after the first rising edge with `PRESETN`=1.
- `cam_rstn` rises RST_CYCLES cycles after `pwdn` falls.
- Write latency:
  - ROM read latency is 1 cycle.
  - First `wr_req` rises 3 cycles after BOOT_WAIT exits (FETCH, LATCH, ISSUE).
  - `wr_req` rising edges of consecutive writes are spaced ≥ GAP_CYCLES+4 cycles apart.
- All outputs are registered. No combinational path from inputs to outputs.
- `PRESETN` asserted mid-operation, including during WAIT_ACK:
  - All outputs return to reset values asynchronously. `wr_req` drops immediately.
  - The sequence restarts from PWDN_WAIT after release.
- `start` and `wr_ack` in the same cycle while in WAIT_ACK: `start` is ignored and `wr_ack` is processed.

## Test plan
- Power-up timing, PWDN_CYCLES=10, RST_CYCLES=20, BOOT_CYCLES=30:
  - `pwdn` falls at cycle 10, `cam_rstn` rises at cycle 30, first `wr_req` at cycle 63.
- Table {0x12_80, 0x11_01, 0xFF_xx}, always ACK:
  - Exactly two writes, (0x12,0x80) then (0x11,0x01), with `wr_reg`/`wr_data` stable during `wr_req`.
  - Then `cfg_done`=1, `busy`=0, `rom_addr`=2.
- NACK the first write 3 times, ACK the 4th (MAX_RETRY=3):
  - Four requests to 0x12, then success and `cfg_done`.
- NACK the first write 4 times:
  - ERROR with `cfg_err`=1, `wr_req`=0, no fourth entry fetched.
  - A `start` pulse then reruns the sequence with `pwdn`=1 the next cycle.
- Delay entry 0xFE_02 between two writes:
  - Gap between the two `wr_req` rising edges ≥ 2048+GAP_CYCLES cycles.
- `PRESETN` pulsed low during WAIT_ACK:
  - `wr_req`=0 and `pwdn`=1 immediately.
  - The full sequence restarts and completes.
- `start` during BOOT_WAIT: no effect; BOOT_WAIT duration is unchanged.
